ex_mem_stage_reg: RTL and testbench

EX_MEM_STAGE_REG -- requirements
Module: ex_mem_stage_reg

---
 rtl/ex_mem_stage_reg.sv | 154 +++++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
//==============================================================================
// Module      : ex_mem_stage_reg
// Description : EX/MEM pipeline stage register. It captures the EX-stage
//               result, store data, destination register, control bits and
//               transfer size for use by the MEM stage. Latency is one cycle.
//               Edge priority is reset > flush > stall > load.
//
//               A flush inserts a bubble. It clears the valid flag, the
//               control bits and the transfer size. The data fields and rdMem
//               keep their current values.
//               A stall holds everything.
//               A load of a non-valid instruction captures the data fields
//               and forces the control bits to zero. As a result,
//               valid_mem=0 always implies that no write is enabled.
//
// Ports       : clk, reset            - clock, synchronous active-high reset
//               stall, flush          - pipeline hold / bubble insertion
//               valid_in, alu_out, outDataIn, outRd, reg_wr, mem_wr, mem_rd,
//               ldurb, transfer       - EX-stage inputs
//               valid_mem, aluMem, dataInMem, rdMem, reg_wr_mem, mem_wr_mem,
//               mem_rd_mem, ldurb_mem, transfer_mem - registered MEM outputs
//               stall_cnt, bubble_cnt - performance counters
//
// Options     : `define EX_MEM_PERF_EN adds stall_cnt and bubble_cnt.
//               stall_cnt counts edges with stall=1 and flush=0.
//               bubble_cnt counts flushes and loads with valid_in=0.
//               Both counters wrap modulo 2^CNT_W.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_mem_stage_reg #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int XFER_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] outDataIn,
    input  logic [RD_W-1:0]   outRd,
    input  logic              reg_wr,
    input  logic              mem_wr,
    input  logic              mem_rd,
    input  logic              ldurb,
    input  logic [XFER_W-1:0] transfer,
    output logic              valid_mem,
    output logic [DATA_W-1:0] aluMem,
    output logic [DATA_W-1:0] dataInMem,
    output logic [RD_W-1:0]   rdMem,
    output logic              reg_wr_mem,
    output logic              mem_wr_mem,
    output logic              mem_rd_mem,
    output logic              ldurb_mem,
    output logic [XFER_W-1:0] transfer_mem
`ifdef EX_MEM_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    logic              r_valid;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_data;
    logic [RD_W-1:0]   r_rd;
    logic              r_reg_wr;
    logic              r_mem_wr;
    logic              r_mem_rd;
    logic              r_ldurb;
    logic [XFER_W-1:0] r_transfer;

    // Qualifying the control bits with valid_in keeps a non-valid
    // instruction from ever enabling a write in the MEM stage.
    logic w_ctrl_en;
    assign w_ctrl_en = valid_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_alu      <= '0;
            r_data     <= '0;
            r_rd       <= '0;
            r_reg_wr   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_ldurb    <= 1'b0;
            r_transfer <= '0;
        end else if (flush) begin
            // Bubble: the data fields and rd are deliberately left untouched.
            r_valid    <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_ldurb    <= 1'b0;
            r_transfer <= '0;
        end else if (!stall) begin
            r_valid    <= valid_in;
            r_alu      <= alu_out;
            r_data     <= outDataIn;
            r_rd       <= outRd;
            r_reg_wr   <= reg_wr & w_ctrl_en;
            r_mem_wr   <= mem_wr & w_ctrl_en;
            r_mem_rd   <= mem_rd & w_ctrl_en;
            r_ldurb    <= ldurb  & w_ctrl_en;
            r_transfer <= transfer;
        end
    end

    // All outputs come straight from the flops.
    assign valid_mem    = r_valid;
    assign aluMem       = r_alu;
    assign dataInMem    = r_data;
    assign rdMem        = r_rd;
    assign reg_wr_mem   = r_reg_wr;
    assign mem_wr_mem   = r_mem_wr;
    assign mem_rd_mem   = r_mem_rd;
    assign ldurb_mem    = r_ldurb;
    assign transfer_mem = r_transfer;

`ifdef EX_MEM_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            // A flush takes precedence, so a flushed stall edge counts as a
            // bubble rather than as a stall.
            if (stall && !flush) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush || (!stall && !valid_in)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage_reg.sv
//==============================================================================
// Module      : tb_ex_mem_stage_reg
// Description : Self-checking bench for ex_mem_stage_reg. It contains a
//               behavioural reference model and checks every negedge.
//               It also runs directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ex_mem_stage_reg;

    localparam int DATA_W = 64;
    localparam int RD_W   = 5;
    localparam int XFER_W = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset, stall, flush, valid_in;
    logic [DATA_W-1:0] alu_out, outDataIn;
    logic [RD_W-1:0]   outRd;
    logic              reg_wr, mem_wr, mem_rd, ldurb;
    logic [XFER_W-1:0] transfer;
    logic              valid_mem;
    logic [DATA_W-1:0] aluMem, dataInMem;
    logic [RD_W-1:0]   rdMem;
    logic              reg_wr_mem, mem_wr_mem, mem_rd_mem, ldurb_mem;
    logic [XFER_W-1:0] transfer_mem;
`ifdef EX_MEM_PERF_EN
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(
        .DATA_W(DATA_W), .RD_W(RD_W), .XFER_W(XFER_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .alu_out(alu_out), .outDataIn(outDataIn),
        .outRd(outRd), .reg_wr(reg_wr), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .ldurb(ldurb), .transfer(transfer),
        .valid_mem(valid_mem), .aluMem(aluMem), .dataInMem(dataInMem),
        .rdMem(rdMem), .reg_wr_mem(reg_wr_mem), .mem_wr_mem(mem_wr_mem),
        .mem_rd_mem(mem_rd_mem), .ldurb_mem(ldurb_mem),
        .transfer_mem(transfer_mem)
`ifdef EX_MEM_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    // Reference model: MEM-stage contents as plain variables.
    typedef struct {
        bit              v;
        bit [DATA_W-1:0] alu, data;
        bit [RD_W-1:0]   rd;
        bit              rw, mw, mr, lb;
        bit [XFER_W-1:0] xf;
        int unsigned     stalls, bubbles;
    } stage_t;
    stage_t m;

    always @(posedge clk) begin
        if (reset) begin
            m = '{default: 0};
        end else if (flush) begin
            m.v = 0; m.rw = 0; m.mw = 0; m.mr = 0; m.lb = 0; m.xf = 0;
            m.bubbles = (m.bubbles + 1) % (1 << CNT_W);
        end else if (stall) begin
            m.stalls = (m.stalls + 1) % (1 << CNT_W);
        end else begin
            m.v = valid_in; m.alu = alu_out; m.data = outDataIn; m.rd = outRd;
            m.rw = valid_in && reg_wr; m.mw = valid_in && mem_wr;
            m.mr = valid_in && mem_rd; m.lb = valid_in && ldurb;
            m.xf = transfer;
            if (!valid_in) m.bubbles = (m.bubbles + 1) % (1 << CNT_W);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("valid_mem", 64'(valid_mem), 64'(m.v));
            chk("aluMem", aluMem, m.alu);
            chk("dataInMem", dataInMem, m.data);
            chk("rdMem", 64'(rdMem), 64'(m.rd));
            chk("reg_wr_mem", 64'(reg_wr_mem), 64'(m.rw));
            chk("mem_wr_mem", 64'(mem_wr_mem), 64'(m.mw));
            chk("mem_rd_mem", 64'(mem_rd_mem), 64'(m.mr));
            chk("ldurb_mem", 64'(ldurb_mem), 64'(m.lb));
            chk("transfer_mem", 64'(transfer_mem), 64'(m.xf));
`ifdef EX_MEM_PERF_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m.stalls));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(m.bubbles));
`endif
        end
    end

    task automatic idle_inputs();
        reset = 0; stall = 0; flush = 0; valid_in = 0;
        alu_out = '0; outDataIn = '0; outRd = '0;
        reg_wr = 0; mem_wr = 0; mem_rd = 0; ldurb = 0; transfer = '0;
    endtask

    task automatic rand_inputs();
        valid_in  = ($urandom_range(0, 3) != 0);
        alu_out   = {$urandom, $urandom};
        outDataIn = {$urandom, $urandom};
        outRd     = RD_W'($urandom);
        reg_wr = $urandom_range(0, 1); mem_wr = $urandom_range(0, 1);
        mem_rd = $urandom_range(0, 1); ldurb  = $urandom_range(0, 1);
        transfer  = XFER_W'($urandom);
    endtask

    // Advance one edge; outputs are settled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rand_inputs();
        reset = 1; stall = 1; flush = 1;
        step();
        check_en = 1'b1;
        step();
        chk("reset valid", 64'(valid_mem), 64'd0);
        chk("reset alu", aluMem, 64'd0);
        chk("reset xfer", 64'(transfer_mem), 64'd0);

        // Basic load.
        idle_inputs();
        valid_in = 1; alu_out = 64'h1234; outRd = 7; reg_wr = 1;
        step();
        chk("load alu", aluMem, 64'h1234);
        chk("load rd", 64'(rdMem), 64'd7);
        chk("load reg_wr", 64'(reg_wr_mem), 64'd1);
        chk("load valid", 64'(valid_mem), 64'd1);

        // Three stalled edges while the inputs change.
        stall = 1; alu_out = 64'hFFFF; outRd = 3;
        repeat (3) step();
        chk("stall alu", aluMem, 64'h1234);
        chk("stall rd", 64'(rdMem), 64'd7);
        chk("stall valid", 64'(valid_mem), 64'd1);
`ifdef EX_MEM_PERF_EN
        chk("stall_cnt 3", 64'(stall_cnt), 64'd3);
`endif

        // Load a store, then flush and stall on the same edge.
        idle_inputs();
        valid_in = 1; mem_wr = 1; alu_out = 64'hABCD; transfer = 4'h8;
        step();
        chk("store mem_wr", 64'(mem_wr_mem), 64'd1);
        stall = 1; flush = 1; alu_out = 64'h9999;
        step();
        chk("flush valid", 64'(valid_mem), 64'd0);
        chk("flush mem_wr", 64'(mem_wr_mem), 64'd0);
        chk("flush alu held", aluMem, 64'hABCD);
        chk("flush xfer", 64'(transfer_mem), 64'd0);
`ifdef EX_MEM_PERF_EN
        chk("bubble_cnt 1", 64'(bubble_cnt), 64'd1);
`endif

        // Non-valid load: controls are dropped, data is kept.
        idle_inputs();
        valid_in = 0; mem_wr = 1; reg_wr = 1; alu_out = 64'h55;
        step();
        chk("nv mem_wr", 64'(mem_wr_mem), 64'd0);
        chk("nv reg_wr", 64'(reg_wr_mem), 64'd0);
        chk("nv alu", aluMem, 64'h55);

        // Make every field nonzero, then reset while stalled.
        idle_inputs();
        valid_in = 1; alu_out = '1; outDataIn = '1; outRd = '1;
        reg_wr = 1; mem_wr = 1; mem_rd = 1; ldurb = 1; transfer = '1;
        step();
        stall = 1;
        step();
        reset = 1;
        step();
        chk("rst-stall valid", 64'(valid_mem), 64'd0);
        chk("rst-stall alu", aluMem, 64'd0);
        chk("rst-stall data", dataInMem, 64'd0);
        chk("rst-stall ctrl",
            64'({reg_wr_mem, mem_wr_mem, mem_rd_mem, ldurb_mem, rdMem}), 64'd0);
`ifdef EX_MEM_PERF_EN
        chk("rst-stall cnts", 64'({stall_cnt, bubble_cnt}), 64'd0);
`endif

        // Seventeen stalls wrap a 4-bit counter to 1.
        reset = 0;
        repeat (17) step();
`ifdef EX_MEM_PERF_EN
        chk("stall_cnt wrap", 64'(stall_cnt), 64'd1);
`endif
        chk("long stall valid", 64'(valid_mem), 64'd0);

        // Randomised traffic, with occasional reset, flush and stall.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            reset = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            step();
        end

        idle_inputs();
        step();
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
